// File: rtl/trade_arbiter_pkg.sv
// Shared types and defaults for the trade session arbiter and its counter.
// The default trade limit lives here so the arbiter and the counter agree on it.
package trade_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    GRANT = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_MAX_TRADES = 8'd100;
  localparam logic [7:0] DEFAULT_QUOTA      = 8'd32;

endpackage

// File: rtl/trade_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request scanning
// upward from ptr+1, wrapping modulo NUM_REQ.
module rr_pick
  import trade_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic                       o_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] w_lane;

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_lane  = '0;
    // Walk from the farthest offset to the nearest so the lane right after
    // the pointer is written last and therefore wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_lane = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_lane]) begin
        o_valid = 1'b1;
        o_idx   = w_lane;
      end
    end
  end

endmodule

// File: rtl/trade_arbiter.sv
// Session controller and round-robin arbiter feeding the shared trade counter.
// Optional per-lane grant quota is built when TRADE_ARB_QUOTA_EN is defined.
module trade_arbiter
  import trade_arb_pkg::*;
#(
  parameter int         NUM_REQ    = 4,
  parameter logic [7:0] MAX_TRADES = DEFAULT_MAX_TRADES,
  parameter logic [7:0] QUOTA      = DEFAULT_QUOTA
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       session_start,
  input  logic                       session_stop,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       halt_in,
  input  logic [7:0]                 trade_count_in,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       match_out,
  output logic                       enable_count,
  output logic                       counter_clear,
  output logic [2:0]                 state_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             r_state;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_match;
  logic               r_enable;
  logic               r_clear;
  logic [IDX_W-1:0]   r_grant_id;
  logic [IDX_W-1:0]   r_ptr;

  logic [NUM_REQ-1:0] w_eligible;
  logic               w_valid;
  logic [IDX_W-1:0]   w_win;
  logic               w_limit;
  logic               w_grant_go;

  // The count is checked every RUN cycle, so a grant can never push it past the limit.
  assign w_limit    = halt_in || (trade_count_in >= MAX_TRADES);
  assign w_grant_go = (r_state == RUN) && !w_limit && !session_stop && w_valid;

`ifdef TRADE_ARB_QUOTA_EN
  logic [7:0] r_quota [NUM_REQ];

  // NOTE: the quota counters are a handful of flops, not a RAM, so they take
  // the async reset like any other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_quota[i] <= '0;
    end else if (r_state == CLEAR) begin
      for (int i = 0; i < NUM_REQ; i++) r_quota[i] <= '0;
    end else if (w_grant_go) begin
      r_quota[w_win] <= r_quota[w_win] + 8'd1;
    end
  end

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = req[i] && (r_quota[i] != QUOTA);
    end
  end
`else
  logic w_unused_quota;

  assign w_eligible     = req;
  assign w_unused_quota = ^QUOTA;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req   (w_eligible),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_idx   (w_win)
  );

  // Outputs are computed on entry to each state so they are all registered.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ack      <= '0;
      r_match    <= 1'b0;
      r_enable   <= 1'b0;
      r_clear    <= 1'b0;
      r_grant_id <= '0;
      r_ptr      <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_ack   <= '0;
      r_match <= 1'b0;
      r_clear <= 1'b0;
      case (r_state)
        IDLE: begin
          r_enable <= 1'b0;
          if (session_start) begin
            r_state <= CLEAR;
            r_clear <= 1'b1;
          end
        end
        CLEAR: begin
          r_state  <= RUN;
          r_enable <= 1'b1;
          r_ptr    <= IDX_W'(NUM_REQ - 1);
        end
        RUN: begin
          if (w_limit) begin
            r_state  <= HALT;
            r_enable <= 1'b0;
          end else if (session_stop) begin
            r_state  <= IDLE;
            r_enable <= 1'b0;
          end else if (w_valid) begin
            r_state    <= GRANT;
            r_ack      <= NUM_REQ'(1) << w_win;
            r_match    <= 1'b1;
            r_grant_id <= w_win;
            r_ptr      <= w_win;
          end
        end
        GRANT: begin
          // Dropping match_out here re-arms the counter's edge detector.
          r_state <= RUN;
        end
        HALT: begin
          if (session_stop) begin
            r_state <= IDLE;
          end else if (session_start) begin
            r_state <= CLEAR;
            r_clear <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_enable <= 1'b0;
        end
      endcase
    end
  end

  assign ack           = r_ack;
  assign grant_id      = r_grant_id;
  assign match_out     = r_match;
  assign enable_count  = r_enable;
  assign counter_clear = r_clear;
  assign state_o       = r_state;

endmodule
